dmem_arbiter: RTL and testbench

Two-port arbiter sharing the single `data_mem` instance between the core load/store unit (port 0) and a debug/DMA master (port 1). Each cycle it selects at most one requester and drives the memory's position, write-enable, byte-enable and write-data lines from that requester. It captures the memory's combinational read data into a per-port register with a one-cycle valid pulse. Selection is either core-priority with a starvation guard for port 1 or plain round-robin.

---
 rtl/dmem_arbiter.sv | 92 +++++++++
 tb/tb_dmem_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data_mem between the core LSU (port 0) and a debug/DMA master (port 1),
// with core-priority-plus-starvation-guard or round-robin selection and registered per-port load data.
module dmem_arbiter #(
  parameter int MP_WIDTH     = 32,
  parameter int MP_CORE_PRIO = 1,
  parameter int MP_MAX_WAIT  = 8
) (
  input  logic                iclk,
  input  logic                irst,
  input  logic                ireq0,
  input  logic                ireq1,
  input  logic                iwen0,
  input  logic                iwen1,
  input  logic [1:0]          ibe0,
  input  logic [1:0]          ibe1,
  input  logic [MP_WIDTH-1:0] ipos0,
  input  logic [MP_WIDTH-1:0] ipos1,
  input  logic [MP_WIDTH-1:0] iwdata0,
  input  logic [MP_WIDTH-1:0] iwdata1,
  output logic                ognt0,
  output logic                ognt1,
  output logic [MP_WIDTH-1:0] ordata0,
  output logic [MP_WIDTH-1:0] ordata1,
  output logic                ordvalid0,
  output logic                ordvalid1,
  output logic                oerr0,
  output logic                oerr1,
  output logic [MP_WIDTH-1:0] omem_pos,
  output logic                omem_wen,
  output logic [1:0]          omem_be,
  output logic [MP_WIDTH-1:0] omem_wdata,
  input  logic [MP_WIDTH-1:0] imem_rdata
);
  localparam logic [7:0] MAXW = 8'(MP_MAX_WAIT);
  localparam logic PRIO = MP_CORE_PRIO != 0;
  logic                rlast_q, rlast_d;
  logic [7:0]          rwait_q, rwait_d;
  logic [MP_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                rdv0_q, rdv0_d, rdv1_q, rdv1_d;
  logic                err0_q, err0_d, err1_q, err1_d;
  logic                g0, g1, bad0, bad1, ld0, ld1;
  always_comb begin
    bad0 = ibe0 == 2'b11;
    bad1 = ibe1 == 2'b11;
    // port 1 wins a tie only when starved (priority mode) or when port 0 went last (round-robin)
    g1 = ~irst & ireq1 & (~ireq0 | (PRIO ? rwait_q == MAXW : ~rlast_q));
    g0 = ~irst & ireq0 & ~g1;
    ld0 = g0 & ~iwen0 & ~bad0;
    ld1 = g1 & ~iwen1 & ~bad1;
    omem_pos = g1 ? ipos1 : ipos0;
    omem_be = g1 ? ibe1 : ibe0;
    omem_wdata = g1 ? iwdata1 : iwdata0;
    omem_wen = g1 ? iwen1 & ~bad1 : g0 & iwen0 & ~bad0;
    rlast_d = g1 | (rlast_q & ~g0);
    rwait_d = (!PRIO || !ireq1 || g1) ? 8'd0 : (rwait_q == MAXW ? MAXW : rwait_q + 8'd1);
    rdata0_d = ld0 ? imem_rdata : rdata0_q;
    rdata1_d = ld1 ? imem_rdata : rdata1_q;
    rdv0_d = ld0;
    rdv1_d = ld1;
    err0_d = g0 & bad0;
    err1_d = g1 & bad1;
  end
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      rlast_q <= 1'b1;
      rwait_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      rdv0_q <= 1'b0;
      rdv1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
    end else begin
      rlast_q <= rlast_d;
      rwait_q <= rwait_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      rdv0_q <= rdv0_d;
      rdv1_q <= rdv1_d;
      err0_q <= err0_d;
      err1_q <= err1_d;
    end
  end
  assign ognt0 = g0;
  assign ognt1 = g1;
  assign ordata0 = rdata0_q;
  assign ordata1 = rdata1_q;
  assign ordvalid0 = rdv0_q;
  assign ordvalid1 = rdv1_q;
  assign oerr0 = err0_q;
  assign oerr1 = err1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: runs a core-priority instance (max wait 3) and a round-robin instance side by side,
// each on its own behavioural byte memory, against a rule-level model of grants, memory and read returns.
module tb_dmem_arbiter;
  localparam int W = 32;
  localparam int MAXW = 3;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic req0[2], req1[2], wen0[2], wen1[2];
  logic gnt0[2], gnt1[2], dv0[2], dv1[2], err0[2], err1[2], mwen[2];
  logic [1:0] be0[2], be1[2], mbe[2];
  logic [W-1:0] pos0[2], pos1[2], wd0[2], wd1[2], rd0[2], rd1[2], mpos[2], mwd[2], mrd[2];
  logic [7:0] mem[2][64];
  logic [7:0] ref_mem[2][64];
  int last[2], wt[2], lastg[2];
  logic e_dv0[2], e_dv1[2], e_e0[2], e_e1[2];
  logic [W-1:0] e_d0[2], e_d1[2];
  int total = 0;
  int bad = 0;

  dmem_arbiter #(.MP_WIDTH(W), .MP_CORE_PRIO(1), .MP_MAX_WAIT(MAXW)) u_prio (
    .iclk(clk), .irst(rst), .ireq0(req0[0]), .ireq1(req1[0]), .iwen0(wen0[0]), .iwen1(wen1[0]),
    .ibe0(be0[0]), .ibe1(be1[0]), .ipos0(pos0[0]), .ipos1(pos1[0]), .iwdata0(wd0[0]), .iwdata1(wd1[0]),
    .ognt0(gnt0[0]), .ognt1(gnt1[0]), .ordata0(rd0[0]), .ordata1(rd1[0]), .ordvalid0(dv0[0]),
    .ordvalid1(dv1[0]), .oerr0(err0[0]), .oerr1(err1[0]), .omem_pos(mpos[0]), .omem_wen(mwen[0]),
    .omem_be(mbe[0]), .omem_wdata(mwd[0]), .imem_rdata(mrd[0]));

  dmem_arbiter #(.MP_WIDTH(W), .MP_CORE_PRIO(0), .MP_MAX_WAIT(MAXW)) u_rr (
    .iclk(clk), .irst(rst), .ireq0(req0[1]), .ireq1(req1[1]), .iwen0(wen0[1]), .iwen1(wen1[1]),
    .ibe0(be0[1]), .ibe1(be1[1]), .ipos0(pos0[1]), .ipos1(pos1[1]), .iwdata0(wd0[1]), .iwdata1(wd1[1]),
    .ognt0(gnt0[1]), .ognt1(gnt1[1]), .ordata0(rd0[1]), .ordata1(rd1[1]), .ordvalid0(dv0[1]),
    .ordvalid1(dv1[1]), .oerr0(err0[1]), .oerr1(err1[1]), .omem_pos(mpos[1]), .omem_wen(mwen[1]),
    .omem_be(mbe[1]), .omem_wdata(mwd[1]), .imem_rdata(mrd[1]));

  // data_mem stand-in: little-endian bytes, word-aligned combinational read, sized write at the edge
  always_comb
    for (int k = 0; k < 2; k++)
      mrd[k] = {mem[k][{mpos[k][5:2], 2'b11}], mem[k][{mpos[k][5:2], 2'b10}],
                mem[k][{mpos[k][5:2], 2'b01}], mem[k][{mpos[k][5:2], 2'b00}]};

  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (rst) begin
        for (int a = 0; a < 64; a++) mem[k][a] <= 8'(a * 7 + k);
      end else if (mwen[k]) begin
        for (int b = 0; b < 4; b++)
          if (b < (1 << mbe[k])) mem[k][6'(mpos[k][5:0] + 6'(b))] <= mwd[k][8*b +: 8];
      end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rword(int k, logic [31:0] p);
    int a;
    a = int'(p[5:2]) * 4;
    return {ref_mem[k][a+3], ref_mem[k][a+2], ref_mem[k][a+1], ref_mem[k][a]};
  endfunction

  // one cycle: inputs were set at the preceding negedge; check, advance the model, return at next negedge
  task automatic step();
    int g;
    logic w;
    logic [1:0] b;
    logic [31:0] p, d;
    string s;
    #1;
    if (rst)
      for (int k = 0; k < 2; k++) begin
        last[k] = 1; wt[k] = 0;
        e_dv0[k] = 0; e_dv1[k] = 0; e_e0[k] = 0; e_e1[k] = 0; e_d0[k] = '0; e_d1[k] = '0;
        for (int a = 0; a < 64; a++) ref_mem[k][a] = 8'(a * 7 + k);
      end
    for (int k = 0; k < 2; k++) begin
      s = (k == 0) ? "prio" : "rr";
      if (rst || !(req0[k] || req1[k])) g = -1;
      else if (!req1[k]) g = 0;
      else if (!req0[k]) g = 1;
      else if (k == 0) g = (wt[k] == MAXW) ? 1 : 0;
      else g = (last[k] == 0) ? 1 : 0;
      w = (g == 1) ? wen1[k] : wen0[k];
      b = (g == 1) ? be1[k] : be0[k];
      p = (g == 1) ? pos1[k] : pos0[k];
      d = (g == 1) ? wd1[k] : wd0[k];
      chk({s, "_gnt0"}, 32'(gnt0[k]), 32'(g == 0));
      chk({s, "_gnt1"}, 32'(gnt1[k]), 32'(g == 1));
      chk({s, "_mem_wen"}, 32'(mwen[k]), 32'(g >= 0 && w && b != 2'b11));
      if (g >= 0) begin
        chk({s, "_mem_pos"}, mpos[k], p);
        chk({s, "_mem_be"}, 32'(mbe[k]), 32'(b));
        chk({s, "_mem_wdata"}, mwd[k], d);
      end
      chk({s, "_rdvalid0"}, 32'(dv0[k]), 32'(e_dv0[k]));
      chk({s, "_rdvalid1"}, 32'(dv1[k]), 32'(e_dv1[k]));
      chk({s, "_err0"}, 32'(err0[k]), 32'(e_e0[k]));
      chk({s, "_err1"}, 32'(err1[k]), 32'(e_e1[k]));
      chk({s, "_rdata0"}, rd0[k], e_d0[k]);
      chk({s, "_rdata1"}, rd1[k], e_d1[k]);
      lastg[k] = g;
      if (!rst) begin
        e_dv0[k] = g == 0 && !w && b != 2'b11;
        e_dv1[k] = g == 1 && !w && b != 2'b11;
        if (e_dv0[k]) e_d0[k] = rword(k, p);
        if (e_dv1[k]) e_d1[k] = rword(k, p);
        e_e0[k] = g == 0 && b == 2'b11;
        e_e1[k] = g == 1 && b == 2'b11;
        if (g >= 0 && w && b != 2'b11)
          for (int i = 0; i < (1 << b); i++) ref_mem[k][6'(p[5:0] + 6'(i))] = d[8*i +: 8];
        if (g >= 0) last[k] = g;
        wt[k] = (k == 1 || !req1[k] || g == 1) ? 0 : (wt[k] == MAXW ? MAXW : wt[k] + 1);
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(int port, logic r, logic w, logic [1:0] b, logic [31:0] p, logic [31:0] d);
    for (int k = 0; k < 2; k++)
      if (port == 0) begin
        req0[k] = r; wen0[k] = w; be0[k] = b; pos0[k] = p; wd0[k] = d;
      end else begin
        req1[k] = r; wen1[k] = w; be1[k] = b; pos1[k] = p; wd1[k] = d;
      end
  endtask

  task automatic idle();
    drive(0, 0, 0, 2'd0, 32'h0, 32'h0);
    drive(1, 0, 0, 2'd0, 32'h0, 32'h0);
  endtask

  // requesters hold a request until granted, then may issue a fresh one
  task automatic rand_run(int n, int pct);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (!req0[k] || lastg[k] == 0) begin
          req0[k] = $urandom_range(0, 9) < pct;
          wen0[k] = 1'($urandom);
          be0[k] = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
          pos0[k] = 32'($urandom_range(0, 63));
          wd0[k] = $urandom;
        end
        if (!req1[k] || lastg[k] == 1) begin
          req1[k] = $urandom_range(0, 9) < pct;
          wen1[k] = 1'($urandom);
          be1[k] = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
          pos1[k] = 32'($urandom_range(0, 63));
          wd1[k] = $urandom;
        end
      end
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    lastg[0] = -1;
    lastg[1] = -1;
    idle();
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    drive(0, 1, 1, 2'd2, 32'h10, 32'hDEADBEEF);
    step();
    drive(0, 1, 0, 2'd2, 32'h10, 32'h0);
    step();
    idle();
    step();
    chk("deadbeef_load", rd0[0], 32'hDEADBEEF);
    drive(1, 1, 1, 2'd0, 32'h13, 32'h000000AA);
    step();
    idle();
    drive(0, 1, 0, 2'd2, 32'h10, 32'h0);
    step();
    idle();
    step();
    chk("byte_aa_lane", 32'(rd0[0][31:24]), 32'hAA);
    drive(0, 1, 1, 2'd3, 32'h20, 32'h12345678);
    step();
    idle();
    step();
    drive(0, 1, 0, 2'd2, 32'h10, 32'h0);
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    drive(0, 1, 0, 2'd2, 32'h4, 32'h0);
    drive(1, 1, 0, 2'd2, 32'h8, 32'h0);
    step();
    chk("prio_tie_after_rst", 32'(lastg[0]), 32'd0);
    chk("rr_tie_after_rst", 32'(lastg[1]), 32'd0);
    rand_run(400, 7);
    rand_run(200, 10);
    rand_run(200, 3);
    idle();
    step();
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 64; a++) chk("mem_final", 32'(mem[k][a]), 32'(ref_mem[k][a]));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
